// File: rtl/spi_shift_core.sv
// spi_shift_core: master-mode SPI serial engine.
//
// Generates the baud clock sclk from pclk, drives ss/mosi, shifts in miso and
// returns the received word on miso_data together with a one-cycle
// receive_data pulse. Slave mode is not supported; mstr=0 keeps the block idle
// and aborts a running transfer.
//
// Ports:
//   pclk, preset_n        system clock, asynchronous active-low reset
//   mstr, cpol, cpha      master enable, clock polarity, clock phase
//   lsbfe, spiswai        LSB-first enable, stop-in-wait enable
//   sppr, spr             baud prescaler / rate select: half = (sppr+1) << spr
//   spi_mode              00 run, 01 wait, 10 stop
//   send_data, mosi_data  start request and word to transmit
//   miso                  serial input
//   sclk, mosi, ss        serial clock, serial output, slave select (active-low)
//   tip                   transfer in progress
//   receive_data          one-cycle pulse when a word completes
//   miso_data             last received word
module spi_shift_core #(
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              mstr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              spiswai,
  input  logic [2:0]        sppr,
  input  logic [2:0]        spr,
  input  logic [1:0]        spi_mode,
  input  logic              send_data,
  input  logic [DATA_W-1:0] mosi_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              tip,
  output logic              receive_data,
  output logic [DATA_W-1:0] miso_data
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state;
  logic [10:0]       baud_cnt;
  logic [10:0]       half_q;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpha_q;
  logic              lsbfe_q;

  logic              freeze;
  logic [10:0]       half_in;
  logic              baud_wrap;
  logic [EW-1:0]     next_edge;
  logic              do_sample;
  logic              do_drive;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] d,
                                                 input logic lsb);
    return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  // LSB-first words enter at the top so the first bit received ends in bit 0.
  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] d,
                                                 input logic lsb,
                                                 input logic b);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  always_comb begin
    freeze    = (spi_mode == 2'b10) || (spi_mode == 2'b01 && spiswai);
    half_in   = ({8'd0, sppr} + 11'd1) << spr;
    baud_wrap = (baud_cnt == half_q - 11'd1);
    next_edge = edge_cnt + EW'(1);
    // Odd edge numbers are leading edges.
    do_sample = baud_wrap && (cpha_q ? !next_edge[0] : next_edge[0]);
    do_drive  = baud_wrap && (cpha_q ? next_edge[0]
                                     : (!next_edge[0] && next_edge != EW'(EDGES)));
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      half_q       <= 11'd1;
      edge_cnt     <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      cpha_q       <= 1'b0;
      lsbfe_q      <= 1'b0;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      ss           <= 1'b1;
      tip          <= 1'b0;
      receive_data <= 1'b0;
      miso_data    <= '0;
    end else begin
      // receive_data is a pulse even if a freeze follows the completing cycle.
      receive_data <= 1'b0;
      if (!freeze) begin
        case (state)
          IDLE: begin
            ss   <= 1'b1;
            tip  <= 1'b0;
            sclk <= cpol;
            if (send_data && mstr) begin
              state    <= XFER;
              ss       <= 1'b0;
              tip      <= 1'b1;
              cpha_q   <= cpha;
              lsbfe_q  <= lsbfe;
              half_q   <= half_in;
              baud_cnt <= '0;
              edge_cnt <= '0;
              rx_sh    <= '0;
              if (!cpha) begin
                mosi  <= first_bit(mosi_data, lsbfe);
                tx_sh <= shift_tx(mosi_data, lsbfe);
              end else begin
                tx_sh <= mosi_data;
              end
            end
          end
          XFER: begin
            if (!mstr) begin
              state <= IDLE;
              ss    <= 1'b1;
              tip   <= 1'b0;
              sclk  <= cpol;
            end else if (baud_wrap) begin
              baud_cnt <= '0;
              sclk     <= ~sclk;
              edge_cnt <= next_edge;
              if (do_sample) rx_sh <= shift_rx(rx_sh, lsbfe_q, miso);
              if (do_drive) begin
                mosi  <= first_bit(tx_sh, lsbfe_q);
                tx_sh <= shift_tx(tx_sh, lsbfe_q);
              end
              if (next_edge == EW'(EDGES)) state <= DONE;
            end else begin
              baud_cnt <= baud_cnt + 11'd1;
            end
          end
          DONE: begin
            miso_data    <= rx_sh;
            receive_data <= 1'b1;
            ss           <= 1'b1;
            tip          <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_core.sv
// tb_spi_shift_core: scoreboard bench for spi_shift_core. A slave model drives
// miso and captures mosi; expected received words are queued at each start and
// popped when receive_data pulses.
module tb_spi_shift_core;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0] sppr, spr;
  logic [1:0] spi_mode;
  logic       send_data;
  logic [7:0] mosi_data;
  logic       miso;
  logic       sclk, mosi, ss, tip, receive_data;
  logic [7:0] miso_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  spi_shift_core #(.DATA_W(8)) dut (
    .pclk(pclk), .preset_n(preset_n), .mstr(mstr), .cpol(cpol), .cpha(cpha),
    .lsbfe(lsbfe), .spiswai(spiswai), .sppr(sppr), .spr(spr),
    .spi_mode(spi_mode), .send_data(send_data), .mosi_data(mosi_data),
    .miso(miso), .sclk(sclk), .mosi(mosi), .ss(ss), .tip(tip),
    .receive_data(receive_data), .miso_data(miso_data)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic slave_bit(input logic [7:0] b, input logic lsb,
                                     input int i);
    logic [7:0] t;
    t = b;
    return lsb ? t[i] : t[7-i];
  endfunction

  // One transfer. Offsets n count falling pclk edges after send_data is driven,
  // which lines up with the cycle offsets from the sampling clock T.
  // Negative frz_at/abort_at/resend_at/rst_at disable that feature.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sl,
                          input logic c_pol, input logic c_pha, input logic c_lsb,
                          input logic [2:0] pp, input logic [2:0] rr,
                          input int frz_at, input int frz_len, input int abort_at,
                          input int resend_at, input int rst_at);
    int h, budget, edges, rises, rise1, rise2, last_edge, f;
    logic prev_sclk, fz_sclk, fz_mosi, fz_ok, got_rd, normal, quiet;
    logic [7:0] mcap, md_before, expv;
    h = (int'(pp) + 1) << int'(rr);
    f = (frz_at > 0) ? frz_len : 0;
    normal = (abort_at < 0) && (rst_at < 0);
    edges = 0; rises = 0; rise1 = 0; rise2 = 0; last_edge = 0;
    fz_ok = 1'b1; got_rd = 1'b0; mcap = '0; fz_sclk = 1'b0; fz_mosi = 1'b0;
    budget = 16 * h + f + 40;

    @(negedge pclk);
    cpol = c_pol; cpha = c_pha; lsbfe = c_lsb; sppr = pp; spr = rr;
    mstr = 1'b1; spi_mode = 2'b00;
    @(negedge pclk);
    @(negedge pclk);
    check_val("sclk_idle", sclk, c_pol);
    mosi_data = tx;
    send_data = 1'b1;
    if (!c_pha) miso = slave_bit(sl, c_lsb, 0);
    if (normal) exp_q.push_back(sl);
    md_before = miso_data;
    prev_sclk = sclk;

    for (int n = 1; n <= budget; n++) begin
      @(negedge pclk);
      send_data = (n == resend_at);
      if (n == 1) begin
        check_val("ss_start", ss, 1'b0);
        check_val("tip_start", tip, 1'b1);
      end
      if (sclk !== prev_sclk) begin
        edges++;
        last_edge = n;
        if (sclk) begin
          rises++;
          if (rises == 1) rise1 = n;
          if (rises == 2) rise2 = n;
        end
        if (!c_pha) begin
          if (edges % 2 == 1) mcap = c_lsb ? {mosi, mcap[7:1]} : {mcap[6:0], mosi};
          else if (edges < 16) miso = slave_bit(sl, c_lsb, edges / 2);
        end else begin
          if (edges % 2 == 1) miso = slave_bit(sl, c_lsb, (edges - 1) / 2);
          else mcap = c_lsb ? {mosi, mcap[7:1]} : {mcap[6:0], mosi};
        end
        prev_sclk = sclk;
      end
      if (frz_at > 0 && n == frz_at) begin
        spi_mode = 2'b10;
        fz_sclk = sclk;
        fz_mosi = mosi;
      end else if (frz_at > 0 && n > frz_at && n <= frz_at + frz_len) begin
        if (sclk !== fz_sclk || mosi !== fz_mosi) fz_ok = 1'b0;
        if (n == frz_at + frz_len) spi_mode = 2'b00;
      end
      if (receive_data) begin
        got_rd = 1'b1;
        if (normal) begin
          check_val("rd_time", n, 2 + 16 * h + f);
          if (exp_q.size() == 0) begin
            check_val("sb_empty", 1, 0);
          end else begin
            expv = exp_q.pop_front();
            check_val("miso_data", miso_data, expv);
          end
          check_val("ss_done", ss, 1'b1);
          check_val("tip_done", tip, 1'b0);
          break;
        end else begin
          check_val("rd_after_abort", 1, 0);
        end
      end
      if (n == abort_at) mstr = 1'b0;
      if (abort_at > 0 && n == abort_at + 1) begin
        check_val("abort_ss", ss, 1'b1);
        check_val("abort_tip", tip, 1'b0);
        check_val("abort_sclk", sclk, c_pol);
      end
      if (abort_at > 0 && n == abort_at + 30) break;
      if (n == rst_at) begin
        #2 preset_n = 1'b0;
        #1;
        check_val("arst_sclk", sclk, 1'b0);
        check_val("arst_mosi", mosi, 1'b0);
        check_val("arst_ss", ss, 1'b1);
        check_val("arst_tip", tip, 1'b0);
        check_val("arst_rd", receive_data, 1'b0);
        check_val("arst_miso_data", miso_data, 8'h00);
        @(negedge pclk);
        preset_n = 1'b1;
        break;
      end
    end
    send_data = 1'b0;

    if (normal) begin
      check_val("rd_seen", got_rd, 1'b1);
      check_val("mosi_word", mcap, tx);
      check_val("sclk_edges", edges, 16);
      check_val("sclk_rises", rises, 8);
      check_val("last_edge_time", last_edge, 1 + 16 * h + f);
      check_val("sclk_period", rise2 - rise1, 2 * h);
      if (frz_at > 0) check_val("freeze_hold", fz_ok, 1'b1);
      @(negedge pclk);
      check_val("rd_pulse_width", receive_data, 1'b0);
      if (resend_at > 0) begin
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
          @(negedge pclk);
          if (ss !== 1'b1 || tip !== 1'b0) quiet = 1'b0;
        end
        check_val("resend_ignored", quiet, 1'b1);
      end
    end else if (abort_at > 0) begin
      check_val("abort_no_rd", got_rd, 1'b0);
      check_val("abort_miso_data", miso_data, md_before);
      check_val("abort_ss_idle", ss, 1'b1);
      mstr = 1'b1;
    end
    @(negedge pclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset_n = 1'b0;
    mstr = 1'b1; cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; spiswai = 1'b0;
    sppr = 3'd0; spr = 3'd0; spi_mode = 2'b00; send_data = 1'b0;
    mosi_data = 8'h00; miso = 1'b0;
    repeat (3) @(negedge pclk);
    check_val("rst_sclk", sclk, 1'b0);
    check_val("rst_ss", ss, 1'b1);
    check_val("rst_tip", tip, 1'b0);
    check_val("rst_mosi", mosi, 1'b0);
    check_val("rst_rd", receive_data, 1'b0);
    check_val("rst_miso_data", miso_data, 8'h00);
    preset_n = 1'b1;
    @(negedge pclk);
    check_val("sclk_follows_cpol", sclk, 1'b1);

    // tx, slave, cpol, cpha, lsbfe, sppr, spr, frz_at, frz_len, abort, resend, rst
    run_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0, -1, -1, -1);
    run_xfer(8'h01, 8'h80, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, -1, 0, -1, -1, -1);
    run_xfer(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 3'd2, 3'd1, -1, 0, -1, -1, -1);
    run_xfer(8'h96, 8'h69, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0,  7, 5, -1, -1, -1);
    run_xfer(8'h3C, 8'hA5, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, -1, 0, -1,  4, -1);
    run_xfer(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0,  8,  3, -1);
    run_xfer(8'hFF, 8'h55, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0, -1, -1,  6);
    run_xfer(8'hC9, 8'h1E, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, -1, 0, -1, -1, -1);

    check_val("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
